// File: rtl/reg_file.sv
// rtl/reg_file.sv - architectural register file with busy flags and ROB rename tags
module reg_file #(
  parameter int REG_NUM      = 32,
  parameter int ROB_IDX_SIZE = 4,
  parameter int DATA_SIZE    = 32
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    roll_back,
  input  logic [4:0]              de_rs1_in,
  input  logic [4:0]              de_rs2_in,
  output logic                    rs1_busy_out,
  output logic                    rs2_busy_out,
  output logic [DATA_SIZE-1:0]    rs1_val_out,
  output logic [DATA_SIZE-1:0]    rs2_val_out,
  output logic [ROB_IDX_SIZE-1:0] rs1_dep_out,
  output logic [ROB_IDX_SIZE-1:0] rs2_dep_out,
  input  logic                    de_rename_en,
  input  logic [4:0]              de_rd_in,
  input  logic [ROB_IDX_SIZE-1:0] de_rob_idx_in,
  input  logic                    rf_in_en,
  input  logic [ROB_IDX_SIZE-1:0] rf_rob_idx_in,
  input  logic [4:0]              rf_dest_in,
  input  logic [DATA_SIZE-1:0]    rf_val_in
);

  logic [DATA_SIZE-1:0]    r_val  [REG_NUM];
  logic [ROB_IDX_SIZE-1:0] r_tag  [REG_NUM];
  logic [REG_NUM-1:0]      r_busy;

  logic [4:0]              w_src  [2];
  logic                    w_busy [2];
  logic [DATA_SIZE-1:0]    w_val  [2];
  logic [ROB_IDX_SIZE-1:0] w_dep  [2];

  logic w_commit;
  logic w_commit_clear;
  logic w_rename;

  assign w_src[0] = de_rs1_in;
  assign w_src[1] = de_rs2_in;

  assign w_commit       = rf_in_en && (rf_dest_in != 5'd0);
  assign w_commit_clear = w_commit && r_busy[rf_dest_in] && (r_tag[rf_dest_in] == rf_rob_idx_in);
  assign w_rename       = de_rename_en && (de_rd_in != 5'd0) && !roll_back;

  // Lookup sees pre-rename state; a matching commit this cycle is forwarded.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_busy[p] = 1'b0;
      w_val[p]  = '0;
      w_dep[p]  = '0;
      if (w_src[p] != 5'd0) begin
        w_dep[p] = r_tag[w_src[p]];
        if (rf_in_en && (rf_dest_in == w_src[p]) && r_busy[w_src[p]] &&
            (rf_rob_idx_in == r_tag[w_src[p]])) begin
          w_busy[p] = 1'b0;
          w_val[p]  = rf_val_in;
        end else begin
          w_busy[p] = r_busy[w_src[p]];
          w_val[p]  = r_val[w_src[p]];
        end
      end
    end
  end

  assign rs1_busy_out = w_busy[0];
  assign rs2_busy_out = w_busy[1];
  assign rs1_val_out  = w_val[0];
  assign rs2_val_out  = w_val[1];
  assign rs1_dep_out  = w_dep[0];
  assign rs2_dep_out  = w_dep[1];

  // Rename is ordered after the commit clear so it wins on the same register.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_busy <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
    end else if (rdy_in) begin
      if (w_commit) begin
        r_val[rf_dest_in] <= rf_val_in;
      end
      if (roll_back) begin
        r_busy <= '0;
      end else begin
        if (w_commit_clear) begin
          r_busy[rf_dest_in] <= 1'b0;
        end
        if (w_rename) begin
          r_busy[de_rd_in] <= 1'b1;
          r_tag[de_rd_in]  <= de_rob_idx_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed bench for reg_file with a register-file model
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        roll_back = 1'b0;
  logic [4:0]  de_rs1_in = '0;
  logic [4:0]  de_rs2_in = '0;
  logic        rs1_busy_out, rs2_busy_out;
  logic [31:0] rs1_val_out, rs2_val_out;
  logic [3:0]  rs1_dep_out, rs2_dep_out;
  logic        de_rename_en = 1'b0;
  logic [4:0]  de_rd_in = '0;
  logic [3:0]  de_rob_idx_in = '0;
  logic        rf_in_en = 1'b0;
  logic [3:0]  rf_rob_idx_in = '0;
  logic [4:0]  rf_dest_in = '0;
  logic [31:0] rf_val_in = '0;

  int n_vec = 0;
  int n_err = 0;

  reg_file #(.REG_NUM(32), .ROB_IDX_SIZE(4), .DATA_SIZE(32)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
    .de_rs1_in(de_rs1_in), .de_rs2_in(de_rs2_in),
    .rs1_busy_out(rs1_busy_out), .rs2_busy_out(rs2_busy_out),
    .rs1_val_out(rs1_val_out), .rs2_val_out(rs2_val_out),
    .rs1_dep_out(rs1_dep_out), .rs2_dep_out(rs2_dep_out),
    .de_rename_en(de_rename_en), .de_rd_in(de_rd_in), .de_rob_idx_in(de_rob_idx_in),
    .rf_in_en(rf_in_en), .rf_rob_idx_in(rf_rob_idx_in), .rf_dest_in(rf_dest_in),
    .rf_val_in(rf_val_in)
  );

  always #5 clk = ~clk;

  // Model state: plain arrays updated from the rules, one step per accepted edge.
  logic [31:0] m_val  [32];
  logic        m_busy [32];
  logic [3:0]  m_tag  [32];

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
  end

  always @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
    end else if (rdy_in) begin
      logic clr;
      clr = rf_in_en && rf_dest_in != 0 && m_busy[rf_dest_in] && m_tag[rf_dest_in] == rf_rob_idx_in;
      if (rf_in_en && rf_dest_in != 0) m_val[rf_dest_in] = rf_val_in;
      if (roll_back) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else begin
        if (clr) m_busy[rf_dest_in] = 1'b0;
        if (de_rename_en && de_rd_in != 0) begin
          m_busy[de_rd_in] = 1'b1;
          m_tag[de_rd_in]  = de_rob_idx_in;
        end
      end
    end
  end

  function automatic logic [36:0] m_look(input logic [4:0] s);
    if (s == 0) return '0;
    if (rf_in_en && rf_dest_in == s && m_busy[s] && rf_rob_idx_in == m_tag[s])
      return {1'b0, rf_val_in, m_tag[s]};
    return {m_busy[s], m_val[s], m_tag[s]};
  endfunction

  always @(negedge clk) begin
    logic [36:0] e1, e2;
    e1 = m_look(de_rs1_in);
    e2 = m_look(de_rs2_in);
    n_vec++;
    if ({rs1_busy_out, rs1_val_out, rs1_dep_out} !== e1) begin
      n_err++;
      $display("FAIL model_rs1 x%0d at %0t: got busy=%0b val=%h dep=%0d want busy=%0b val=%h dep=%0d",
               de_rs1_in, $time, rs1_busy_out, rs1_val_out, rs1_dep_out, e1[36], e1[35:4], e1[3:0]);
    end
    n_vec++;
    if ({rs2_busy_out, rs2_val_out, rs2_dep_out} !== e2) begin
      n_err++;
      $display("FAIL model_rs2 x%0d at %0t: got busy=%0b val=%h dep=%0d want busy=%0b val=%h dep=%0d",
               de_rs2_in, $time, rs2_busy_out, rs2_val_out, rs2_dep_out, e2[36], e2[35:4], e2[3:0]);
    end
  end

  task automatic chk(input string name, input int port, input logic b,
                     input logic [31:0] v, input logic [3:0] d);
    logic        ab;
    logic [31:0] av;
    logic [3:0]  ad;
    ab = (port == 1) ? rs1_busy_out : rs2_busy_out;
    av = (port == 1) ? rs1_val_out  : rs2_val_out;
    ad = (port == 1) ? rs1_dep_out  : rs2_dep_out;
    n_vec++;
    if (ab !== b || av !== v || ad !== d) begin
      n_err++;
      $display("FAIL %s: got busy=%0b val=%h dep=%0d want busy=%0b val=%h dep=%0d",
               name, ab, av, ad, b, v, d);
    end
  endtask

  task automatic idle();
    de_rename_en = 1'b0; rf_in_en = 1'b0; roll_back = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1; idle();
  endtask

  task automatic rename(input logic [4:0] rd, input logic [3:0] tag);
    de_rename_en = 1'b1; de_rd_in = rd; de_rob_idx_in = tag;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] v);
    rf_in_en = 1'b1; rf_dest_in = rd; rf_rob_idx_in = tag; rf_val_in = v;
  endtask

  initial begin
    #12 rst_in = 1'b1;
    step();

    de_rs1_in = 5'd5; #1 chk("reset_x5", 1, 0, 32'h0, 4'd0);
    commit(5'd0, 4'd0, 32'hDEAD); step();
    de_rs1_in = 5'd0; #1 chk("x0_after_commit", 1, 0, 32'h0, 4'd0);

    rename(5'd3, 4'd2); step();
    de_rs1_in = 5'd3; #1 chk("x3_renamed", 1, 1, 32'h0, 4'd2);
    commit(5'd3, 4'd2, 32'h1234); #1 chk("x3_bypass", 1, 0, 32'h1234, 4'd2);
    step(); chk("x3_committed", 1, 0, 32'h1234, 4'd2);

    rename(5'd4, 4'd1); step();
    rename(5'd4, 4'd5); step();
    de_rs1_in = 5'd4; commit(5'd4, 4'd1, 32'd7); #1 chk("x4_stale_no_bypass", 1, 1, 32'h0, 4'd5);
    step(); chk("x4_still_busy", 1, 1, 32'd7, 4'd5);
    commit(5'd4, 4'd5, 32'd9); #1 chk("x4_bypass", 1, 0, 32'd9, 4'd5);
    step(); chk("x4_done", 1, 0, 32'd9, 4'd5);

    rename(5'd6, 4'd3); step();
    de_rs2_in = 5'd6; commit(5'd6, 4'd3, 32'hAA); rename(5'd6, 4'd8);
    #1 chk("x6_same_cycle_bypass", 2, 0, 32'hAA, 4'd3);
    step(); chk("x6_rename_wins", 2, 1, 32'hAA, 4'd8);

    rename(5'd1, 4'd1); step();
    rename(5'd2, 4'd2); step();
    rename(5'd7, 4'd3); step();
    de_rs1_in = 5'd1; de_rs2_in = 5'd7; #1 chk("x1_busy", 1, 1, 32'h0, 4'd1);
    chk("x7_busy", 2, 1, 32'h0, 4'd3);
    roll_back = 1'b1; rename(5'd9, 4'd4); step();
    de_rs1_in = 5'd1; de_rs2_in = 5'd2; #1 chk("rb_x1", 1, 0, 32'h0, 4'd1);
    chk("rb_x2", 2, 0, 32'h0, 4'd2);
    de_rs1_in = 5'd7; de_rs2_in = 5'd9; #1 chk("rb_x7", 1, 0, 32'h0, 4'd3);
    chk("rb_x9_dropped", 2, 0, 32'h0, 4'd0);
    de_rs1_in = 5'd6; #1 chk("rb_x6", 1, 0, 32'hAA, 4'd8);
    step();

    rdy_in = 1'b0; rename(5'd10, 4'd5); commit(5'd11, 4'd6, 32'h55); step();
    rdy_in = 1'b1;
    de_rs1_in = 5'd10; de_rs2_in = 5'd11; #1 chk("hold_x10", 1, 0, 32'h0, 4'd0);
    chk("hold_x11", 2, 0, 32'h0, 4'd0);

    rename(5'd12, 4'd7); commit(5'd13, 4'd0, 32'h77); step();
    de_rs1_in = 5'd12; de_rs2_in = 5'd13; #1 chk("pre_rst_x12", 1, 1, 32'h0, 4'd7);
    chk("pre_rst_x13", 2, 0, 32'h77, 4'd0);
    rst_in = 1'b0; #1 chk("async_rst_x12", 1, 0, 32'h0, 4'd0);
    chk("async_rst_x13", 2, 0, 32'h0, 4'd0);
    #5 rst_in = 1'b1;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
